// File: rtl/fc_layer_seq_if.sv
// Activation input stream and requantised result stream of the FC layer sequencer.
interface fc_layer_seq_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/fc_layer_seq.sv
// Sequencer for a combinational FC layer: deserialise, settle, capture, requantise, stream out.
// Optional macro FC_SEQ_OVERLAP_EN: load the next frame while the previous result waits in OUT.
//
// state  | meaning
// LOAD   | accepting activation beats into the buffer
// SETTLE | buffer held stable while the layer settles; sum captured when cnt reaches 0
// OUT    | requantised result presented on the output stream
module fc_layer_seq #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int SUM_W  = 23,
  parameter int SETTLE = 2,
  parameter int SHIFT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fc_layer_seq_if.slave         io,
  output logic [IN*WIDTH-1:0]   x_bus,
  input  logic [SUM_W-1:0]      z_in,
  output logic                  busy,
  output logic                  err_len
);

  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
  localparam int CNT_W = $clog2(SETTLE) + 1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE_ST = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
`ifdef FC_SEQ_OVERLAP_EN
  logic               pending;
`endif

  logic               hs_in;
  logic               hs_out;
  logic               last_idx;
  logic               frame_done;
  logic [SUM_W-1:0]   z_sh;
  logic [WIDTH-1:0]   z_sat;

  assign hs_in      = io.s_valid & io.s_ready;
  assign hs_out     = io.m_valid & io.m_ready;
  assign last_idx   = (idx == IDX_W'(IN - 1));
  assign frame_done = hs_in & last_idx;

  assign z_sh  = z_in >> SHIFT;
  assign z_sat = (|z_sh[SUM_W-1:WIDTH]) ? {WIDTH{1'b1}} : z_sh[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      idx        <= '0;
      cnt        <= '0;
      x_bus      <= '0;
      io.s_ready <= 1'b1;
      io.m_valid <= 1'b0;
      io.m_data  <= '0;
      busy       <= 1'b0;
      err_len    <= 1'b0;
`ifdef FC_SEQ_OVERLAP_EN
      pending    <= 1'b0;
`endif
    end else begin
      // Beats are only accepted while s_ready is high, so this is shared by LOAD and overlapped OUT.
      if (hs_in) begin
        x_bus[idx*WIDTH +: WIDTH] <= io.s_data;
        if (last_idx || io.s_last) idx <= '0;
        else                       idx <= idx + 1'b1;
        // s_last missing on the final beat, or present on an earlier one
        if (last_idx != io.s_last) err_len <= 1'b1;
      end

      case (state)
        LOAD: begin
          if (frame_done) begin
            state      <= SETTLE_ST;
            cnt        <= CNT_W'(SETTLE - 1);
            io.s_ready <= 1'b0;
            busy       <= 1'b1;
          end
        end

        SETTLE_ST: begin
          if (cnt == '0) begin
            io.m_data  <= z_sat;
            io.m_valid <= 1'b1;
            state      <= OUT;
`ifdef FC_SEQ_OVERLAP_EN
            io.s_ready <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        OUT: begin
`ifdef FC_SEQ_OVERLAP_EN
          if (hs_out) begin
            io.m_valid <= 1'b0;
            if (pending || frame_done) begin
              pending    <= 1'b0;
              state      <= SETTLE_ST;
              cnt        <= CNT_W'(SETTLE - 1);
              io.s_ready <= 1'b0;
            end else begin
              state      <= LOAD;
              io.s_ready <= 1'b1;
              busy       <= 1'b0;
            end
          end else if (frame_done) begin
            pending    <= 1'b1;
            io.s_ready <= 1'b0;
          end
`else
          if (hs_out) begin
            io.m_valid <= 1'b0;
            state      <= LOAD;
            io.s_ready <= 1'b1;
            busy       <= 1'b0;
          end
`endif
        end

        default: begin
          state      <= LOAD;
          io.s_ready <= 1'b1;
          io.m_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
